mux_pipe_reg: RTL and testbench
===============================

Name: mux_pipe_reg

Overview:
- Parametrised N-input, W-bit selector with a registered, back-pressure-aware output stage.
- Generalises the datapath 2:1 mux to NUM_IN inputs and adds a valid/ready handshake.
- Adds a 2-entry skid buffer so the selected word can cross a pipeline boundary (e.g. ALU-source or writeback select) at full throughput without combinational ready paths.

Parameters:
- WIDTH, 32, data width of each input word and of the output.
- NUM_IN, 4, number of input words; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all buffered data; no reset of configuration.
- in_bus  input  NUM_IN*WIDTH  packed inputs; word k = in_bus[k*WIDTH +: WIDTH].
- sel  input  SEL_W  input word index, sampled with in_valid.
- in_valid  input  1  upstream offers a transfer.
- in_ready  output  1  block can accept; registered (equals !skid_valid).
- out_data  output  WIDTH  selected word, registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- sel_err  output  1  one-cycle pulse: an accepted transfer had sel >= NUM_IN.

Behaviour:
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Emit occurs when out_valid && out_ready.
  - in_valid may be asserted regardless of in_ready; in_bus and sel are only sampled on accept.
- Selection: selected word = in_bus word[sel]. If sel >= NUM_IN (non-power-of-two NUM_IN), the word is all zeros and sel_err = 1 on the cycle after the accept.
- Storage: main register (out_data / out_valid) plus skid register (skid_data / skid_valid).
- State machine, encoded by {out_valid, skid_valid}:
  - EMPTY (0,0):
    - accept -> main loads the word; go to BUSY.
  - BUSY (1,0):
    - accept and emit -> main reloads with the new word; stay BUSY.
    - accept, no emit -> skid loads the word; go to FULL.
    - emit, no accept -> go to EMPTY.
    - neither -> hold.
  - FULL (1,1); in_ready = 0, so no accept:
    - emit -> skid moves into main, skid clears; go to BUSY.
    - no emit -> hold both.
- Timing:
  - Latency: accepted word appears on out_data exactly 1 cycle after accept (EMPTY/BUSY path).
  - Throughput: 1 word/cycle sustained while out_ready = 1.
- Ordering: words emit strictly in acceptance order; no drops, no duplicates.
- Data stability: out_data must not change while out_valid && !out_ready.
- Reset (rst = 1 at posedge):
  - out_valid = 0, skid_valid = 0, out_data = 0, skid_data = 0, sel_err = 0, in_ready = 1 on the next cycle.
  - rst overrides flush and any handshake in the same cycle.
  - A transfer in flight at reset is discarded.
- Flush (flush = 1, rst = 0):
  - Both valid bits clear and sel_err = 0 next cycle; data registers may hold stale values.
  - An accept in the flush cycle is discarded. in_ready still reads its pre-flush value that cycle; the upstream treats the word as consumed.
- Simultaneous emit + accept in FULL cannot occur (in_ready = 0).
- No combinational path from out_ready or in_valid to in_ready.
- Width rules: no arithmetic; all data moves are pure WIDTH-bit copies; sel is compared unsigned against NUM_IN.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W = 32 constant.
  - Localparam-style state encodings ST_EMPTY = 2'b00, ST_BUSY = 2'b10, ST_FULL = 2'b11, used by both the RTL and bench assertions.
- Sub-module mux_nto1 (parametrised WIDTH, NUM_IN): purely combinational selector with out-of-range zeroing and an err flag. mux_pipe_reg instantiates it once and owns all sequential logic.

Test Plan:
- Reset: hold rst 2 cycles with in_valid = 1 -> out_valid = 0, out_data = 0, sel_err = 0, in_ready = 1 after release.
- Streaming: NUM_IN = 4, in_bus words {0x11111111, 0x22222222, 0x33333333, 0x44444444}, sel = 0,1,2,3 on consecutive cycles, out_ready = 1 -> out_data = 0x11111111..0x44444444 on cycles 1..4, out_valid continuous.
- Back-pressure: out_ready = 0 while accepting sel = 2 then sel = 3 -> in_ready drops after the 2nd accept, out_data holds 0x33333333. Raising out_ready -> 0x33333333 then 0x44444444 emitted; in_ready returns to 1 one cycle after the first emit.
- Out-of-range select: NUM_IN = 3, accept with sel = 3 -> out_data = 0x00000000, out_valid = 1, sel_err = 1 for exactly one cycle.
- Flush: reach FULL, then pulse flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and no old or flush-cycle word ever emitted.
- Reset mid-operation: in FULL with out_ready = 0, assert rst 1 cycle -> both entries lost, out_valid = 0. The next accept (sel = 1) emits 0x22222222 with 1-cycle latency.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the datapath select/pipeline blocks.
// Pipeline states are encoded as {out_valid, skid_valid}, so they can be read straight off the ports.
package cpu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } pipe_state_e;

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 word selector.
// An out-of-range select gives an all-zero word and raises err.
module mux_nto1
    import cpu_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_word,
    output logic                    err
);

    // Compare against every legal index. No index matches for sel >= NUM_IN,
    // so the zero default and the error flag both survive.
    always_comb begin
        out_word = '0;
        err      = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                out_word = in_bus[k*WIDTH +: WIDTH];
                err      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_pipe_reg.sv
// N-input word selector with a registered valid/ready output stage and a 2-entry skid buffer.
// in_ready is taken only from state, so ready never depends combinationally on the downstream.
module mux_pipe_reg
    import cpu_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] mux_word;
    logic             mux_err;
    logic             accept, emit;
    logic             load_main, load_skid, skid_to_main;

    mux_nto1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_bus   (in_bus),
        .sel      (sel),
        .out_word (mux_word),
        .err      (mux_err)
    );

    assign out_valid = state_q[1];
    assign in_ready  = ~state_q[0];
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (emit) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    skid_to_main = 1'b1;
                    state_d      = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            out_data  <= '0;
            skid_data <= '0;
            sel_err   <= 1'b0;
        end else if (flush) begin
            // Valid bits drop; data registers keep whatever stale words they hold.
            state_q   <= ST_EMPTY;
            sel_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_err <= accept & mux_err;
            if (load_main)
                out_data <= mux_word;
            else if (skid_to_main)
                out_data <= skid_data;
            if (load_skid)
                skid_data <= mux_word;
        end
    end

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Directed bench for mux_pipe_reg: a 4-input instance for the main scenarios
// and a 3-input instance for the out-of-range select.
module tb_mux_pipe_reg;
    import cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst, flush;
    logic [127:0] in_bus4;
    logic [1:0]   sel4;
    logic         in_valid4, in_ready4, out_valid4, out_ready4, sel_err4;
    logic [31:0]  out_data4;
    logic [95:0]  in_bus3;
    logic [1:0]   sel3;
    logic         in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
    logic [31:0]  out_data3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_pipe_reg #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_bus(in_bus4), .sel(sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .sel_err(sel_err4)
    );

    mux_pipe_reg #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_bus(in_bus3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        in_valid4 = 1'b1; sel4 = 2'd0; out_ready4 = 1'b1;
        in_valid3 = 1'b1; sel3 = 2'd0; out_ready3 = 1'b1;
        step(); step();
        rst = 1'b0; in_valid4 = 1'b0; in_valid3 = 1'b0;
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid4); end
        checks++; if (out_data4 !== 32'h0) begin errors++; $display("FAIL reset out_data got %h exp 00000000", out_data4); end
        checks++; if (sel_err4 !== 1'b0) begin errors++; $display("FAIL reset sel_err got %b exp 0", sel_err4); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready4); end
        checks++; if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin errors++; $display("FAIL reset3 valid/ready got %b%b exp 01", out_valid3, in_ready3); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_w [4];
        exp_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1; sel4 = 2'(i);
            step();
            checks++; if (out_data4 !== exp_w[i] || out_valid4 !== 1'b1) begin errors++; $display("FAIL stream%0d got %h/%b exp %h/1", i, out_data4, out_valid4, exp_w[i]); end
            checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL stream%0d in_ready got %b exp 1", i, in_ready4); end
        end
        in_valid4 = 1'b0;
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL stream drain out_valid got %b exp 0", out_valid4); end
    endtask

    task automatic test_back_pressure();
        out_ready4 = 1'b0;
        in_valid4 = 1'b1; sel4 = 2'd2;
        step();
        checks++; if ({out_valid4, ~in_ready4} !== ST_BUSY || out_data4 !== 32'h33333333) begin errors++; $display("FAIL bp first got st %b data %h exp 10 33333333", {out_valid4, ~in_ready4}, out_data4); end
        sel4 = 2'd3;
        step();
        checks++; if ({out_valid4, ~in_ready4} !== ST_FULL) begin errors++; $display("FAIL bp full got st %b exp 11", {out_valid4, ~in_ready4}); end
        checks++; if (out_data4 !== 32'h33333333) begin errors++; $display("FAIL bp hold got %h exp 33333333", out_data4); end
        // Upstream keeps offering while full; the word must not be taken.
        sel4 = 2'd0;
        step();
        checks++; if (out_data4 !== 32'h33333333 || in_ready4 !== 1'b0) begin errors++; $display("FAIL bp stall got %h/%b exp 33333333/0", out_data4, in_ready4); end
        out_ready4 = 1'b1;
        step();
        checks++; if (out_data4 !== 32'h44444444 || out_valid4 !== 1'b1) begin errors++; $display("FAIL bp skid got %h/%b exp 44444444/1", out_data4, out_valid4); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL bp ready back got %b exp 1", in_ready4); end
        in_valid4 = 1'b0;
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL bp drain got %b exp 0 (stalled word leaked)", out_valid4); end
    endtask

    task automatic test_out_of_range();
        in_bus3 = {32'h33333333, 32'h22222222, 32'h11111111};
        out_ready3 = 1'b1;
        in_valid3 = 1'b1; sel3 = 2'd2;
        step();
        checks++; if (out_data3 !== 32'h33333333 || sel_err3 !== 1'b0) begin errors++; $display("FAIL oor top-legal got %h/%b exp 33333333/0", out_data3, sel_err3); end
        sel3 = 2'd3;
        step();
        checks++; if (out_data3 !== 32'h0 || out_valid3 !== 1'b1) begin errors++; $display("FAIL oor word got %h/%b exp 00000000/1", out_data3, out_valid3); end
        checks++; if (sel_err3 !== 1'b1) begin errors++; $display("FAIL oor sel_err got %b exp 1", sel_err3); end
        in_valid3 = 1'b0;
        step();
        checks++; if (sel_err3 !== 1'b0 || out_valid3 !== 1'b0) begin errors++; $display("FAIL oor pulse got err %b valid %b exp 0 0", sel_err3, out_valid3); end
    endtask

    task automatic test_flush();
        out_ready4 = 1'b0;
        in_valid4 = 1'b1; sel4 = 2'd0; step();
        sel4 = 2'd1; step();
        checks++; if ({out_valid4, ~in_ready4} !== ST_FULL) begin errors++; $display("FAIL flush setup got st %b exp 11", {out_valid4, ~in_ready4}); end
        flush = 1'b1; sel4 = 2'd2;
        step();
        flush = 1'b0; in_valid4 = 1'b0;
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin errors++; $display("FAIL flush full got valid %b ready %b exp 0 1", out_valid4, in_ready4); end
        // Flush while BUSY, with an accept landing in the flush cycle.
        in_valid4 = 1'b1; sel4 = 2'd0; step();
        flush = 1'b1; sel4 = 2'd3; step();
        flush = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL flush busy got valid %b exp 0", out_valid4); end
        step(); step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL flush ghost got valid %b data %h exp 0", out_valid4, out_data4); end
        in_valid4 = 1'b1; sel4 = 2'd1; step();
        in_valid4 = 1'b0;
        checks++; if (out_data4 !== 32'h22222222 || out_valid4 !== 1'b1) begin errors++; $display("FAIL flush resume got %h/%b exp 22222222/1", out_data4, out_valid4); end
        step();
    endtask

    task automatic test_reset_mid_op();
        out_ready4 = 1'b0;
        in_valid4 = 1'b1; sel4 = 2'd2; step();
        sel4 = 2'd3; step();
        checks++; if ({out_valid4, ~in_ready4} !== ST_FULL) begin errors++; $display("FAIL rstmid setup got st %b exp 11", {out_valid4, ~in_ready4}); end
        rst = 1'b1; in_valid4 = 1'b0; step();
        rst = 1'b0;
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out_data4 !== 32'h0) begin errors++; $display("FAIL rstmid clear got %b%b %h exp 01 00000000", out_valid4, in_ready4, out_data4); end
        in_valid4 = 1'b1; sel4 = 2'd1; out_ready4 = 1'b1; step();
        in_valid4 = 1'b0;
        checks++; if (out_data4 !== 32'h22222222 || out_valid4 !== 1'b1) begin errors++; $display("FAIL rstmid next got %h/%b exp 22222222/1", out_data4, out_valid4); end
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rstmid drain got %b exp 0 (old entry survived)", out_valid4); end
    endtask

    initial begin
        in_bus4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        in_bus3 = {32'h33333333, 32'h22222222, 32'h11111111};
        test_reset();
        test_streaming();
        test_back_pressure();
        test_out_of_range();
        test_flush();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
